// File: rtl/diagonal_matrix_pkg.sv
// Shared types and helpers for the streaming matrix-to-diagonal converter.
package diagonal_matrix_pkg;

   typedef enum logic {
      LOAD = 1'b0,
      SEND = 1'b1
   } state_t;

   function automatic int idx_w(input int size);
      return (size < 2) ? 1 : $clog2(size);
   endfunction

endpackage

// File: rtl/matrix_index_counter.sv
// Row-major (row, col) walker over a SIZE x SIZE matrix, advanced by inc.
module matrix_index_counter
   import diagonal_matrix_pkg::*;
#(
   parameter int SIZE = 4,
   localparam int IW = idx_w(SIZE)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          inc,
   output logic [IW-1:0] row,
   output logic [IW-1:0] col,
   output logic          last
);

   localparam logic [IW-1:0] MAX = IW'(SIZE - 1);

   logic [IW-1:0] r_row;
   logic [IW-1:0] r_col;
   logic          w_col_end;

   assign w_col_end = (r_col == MAX);
   assign last      = w_col_end && (r_row == MAX);
   assign row       = r_row;
   assign col       = r_col;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_row <= '0;
         r_col <= '0;
      end else if (inc) begin
         if (w_col_end) begin
            r_col <= '0;
            r_row <= last ? '0 : r_row + 1'b1;
         end else begin
            r_col <= r_col + 1'b1;
         end
      end
   end

endmodule

// File: rtl/diagonal_matrix.sv
// Loads one matrix, keeps only its diagonal, then streams it back out
// with every off-diagonal element forced to zero.
module diagonal_matrix
   import diagonal_matrix_pkg::*;
#(
   parameter int SIZE       = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_tdata,
   input  logic                  in_tvalid,
   output logic                  in_tready,
   output logic [DATA_WIDTH-1:0] out_tdata,
   input  logic                  out_tready,
   output logic                  out_tvalid
);

   localparam int IW = idx_w(SIZE);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_diag [SIZE];

   logic [IW-1:0] w_row;
   logic [IW-1:0] w_col;
   logic          w_last;
   logic          w_on_diag;
   logic          w_in_hs;
   logic          w_out_hs;

   // Gating with rst keeps both handshakes dead during reset.
   assign in_tready  = rst && (r_state == LOAD);
   assign out_tvalid = rst && (r_state == SEND);
   assign w_in_hs    = in_tvalid && in_tready;
   assign w_out_hs   = out_tvalid && out_tready;
   assign w_on_diag  = (w_row == w_col);
   assign out_tdata  = (out_tvalid && w_on_diag) ? r_diag[w_row] : '0;

   matrix_index_counter #(
      .SIZE(SIZE)
   ) u_idx (
      .clk (clk),
      .rst (rst),
      .inc (w_in_hs || w_out_hs),
      .row (w_row),
      .col (w_col),
      .last(w_last)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= LOAD;
         for (int i = 0; i < SIZE; i++) begin
            r_diag[i] <= '0;
         end
      end else begin
         case (r_state)
            LOAD: begin
               if (w_in_hs) begin
                  if (w_on_diag) begin
                     r_diag[w_row] <= in_tdata;
                  end
                  if (w_last) begin
                     r_state <= SEND;
                  end
               end
            end
            SEND: begin
               if (w_out_hs && w_last) begin
                  r_state <= LOAD;
               end
            end
            default: r_state <= LOAD;
         endcase
      end
   end

endmodule

// File: tb/tb_diagonal_matrix.sv
// Directed bench for diagonal_matrix: SIZE=4 and SIZE=6 instances.
module tb_diagonal_matrix;

   logic        clk = 1'b0;
   logic        rst = 1'b0;

   logic [31:0] in_tdata4 = '0;
   logic        in_tvalid4 = 1'b0;
   logic        in_tready4;
   logic [31:0] out_tdata4;
   logic        out_tready4 = 1'b0;
   logic        out_tvalid4;

   logic [31:0] in_tdata6 = '0;
   logic        in_tvalid6 = 1'b0;
   logic        in_tready6;
   logic [31:0] out_tdata6;
   logic        out_tready6 = 1'b0;
   logic        out_tvalid6;

   int total = 0;
   int bad   = 0;

   logic [31:0] got[$];
   int last_in_cyc;
   int first_out_cyc;
   int stall_err;
   int overlap_err;
   int n_send_cyc;

   always #5 clk = ~clk;

   diagonal_matrix #(.SIZE(4), .DATA_WIDTH(32)) u_dut4 (
      .clk       (clk),
      .rst       (rst),
      .in_tdata  (in_tdata4),
      .in_tvalid (in_tvalid4),
      .in_tready (in_tready4),
      .out_tdata (out_tdata4),
      .out_tready(out_tready4),
      .out_tvalid(out_tvalid4)
   );

   diagonal_matrix #(.SIZE(6), .DATA_WIDTH(32)) u_dut6 (
      .clk       (clk),
      .rst       (rst),
      .in_tdata  (in_tdata6),
      .in_tvalid (in_tvalid6),
      .in_tready (in_tready6),
      .out_tdata (out_tdata6),
      .out_tready(out_tready6),
      .out_tvalid(out_tvalid6)
   );

   // Expected SIZE=4 output word k when input word k was base+k.
   function automatic logic [31:0] exp4(input int base, input int k);
      return (k % 5 == 0) ? 32'(base + k) : 32'd0;
   endfunction

   // Drives the SIZE=4 DUT and records accepted outputs.
   task automatic run4(input int base, input int n_in, input int vper,
                       input bit bp, input int max_out);
      int idx = 0;
      int cyc = 0;
      bit stalled = 1'b0;
      logic [31:0] held = '0;
      got.delete();
      stall_err = 0;
      overlap_err = 0;
      n_send_cyc = 0;
      first_out_cyc = -1;
      last_in_cyc = -1;
      while ((idx < n_in || got.size() < max_out) && cyc < 400) begin
         @(negedge clk);
         in_tvalid4 = (idx < n_in) && (cyc % vper == 0);
         in_tdata4 = 32'(base + idx);
         out_tready4 = bp ? (cyc % 2 == 0) : 1'b1;
         #1;
         if (in_tready4 && out_tvalid4) overlap_err++;
         if (out_tvalid4) n_send_cyc++;
         if (stalled && out_tdata4 !== held) stall_err++;
         stalled = out_tvalid4 && !out_tready4;
         held = out_tdata4;
         if (in_tvalid4 && in_tready4) begin
            idx++;
            last_in_cyc = cyc;
         end
         if (out_tvalid4 && out_tready4) begin
            if (got.size() == 0) first_out_cyc = cyc;
            got.push_back(out_tdata4);
         end
         cyc++;
      end
      total++;
      if (cyc >= 400) begin
         bad++;
         $display("FAIL run4_timeout: got %0d outputs, required %0d",
                  got.size(), max_out);
      end
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      total++;
      if (in_tready4 !== 1'b0 || out_tvalid4 !== 1'b0 || out_tdata4 !== '0) begin
         bad++;
         $display("FAIL reset_out4: rdy=%b vld=%b data=%0d, required 0 0 0",
                  in_tready4, out_tvalid4, out_tdata4);
      end
      total++;
      if (in_tready6 !== 1'b0 || out_tvalid6 !== 1'b0) begin
         bad++;
         $display("FAIL reset_out6: rdy=%b vld=%b, required 0 0",
                  in_tready6, out_tvalid6);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (in_tready4 !== 1'b1 || out_tvalid4 !== 1'b0) begin
         bad++;
         $display("FAIL reset_release: rdy=%b vld=%b, required 1 0",
                  in_tready4, out_tvalid4);
      end
   endtask

   task automatic test_basic();
      logic [31:0] exp_a [16] = '{1, 0, 0, 0, 0, 6, 0, 0,
                                  0, 0, 11, 0, 0, 0, 0, 16};
      run4(1, 16, 1, 1'b0, 16);
      total++;
      if (got.size() != 16) begin
         bad++;
         $display("FAIL basic_count: got %0d, required 16", got.size());
      end
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         total++;
         if (got[k] !== exp_a[k]) begin
            bad++;
            $display("FAIL basic_word%0d: got %0d, required %0d",
                     k, got[k], exp_a[k]);
         end
      end
      total++;
      if (first_out_cyc != last_in_cyc + 1) begin
         bad++;
         $display("FAIL basic_latency: first out cyc %0d, required %0d",
                  first_out_cyc, last_in_cyc + 1);
      end
      total++;
      if (n_send_cyc != 16 || overlap_err != 0) begin
         bad++;
         $display("FAIL basic_send: send cycles %0d overlap %0d, required 16 0",
                  n_send_cyc, overlap_err);
      end
      @(negedge clk);
      #1;
      total++;
      if (in_tready4 !== 1'b1 || out_tvalid4 !== 1'b0) begin
         bad++;
         $display("FAIL basic_back_to_load: rdy=%b vld=%b, required 1 0",
                  in_tready4, out_tvalid4);
      end
   endtask

   task automatic test_size6();
      logic [31:0] got6[$];
      int idx = 0;
      int cyc = 0;
      int acc37 = -1;
      int last_out = -1;
      while (acc37 < 0 && cyc < 300) begin
         @(negedge clk);
         in_tvalid6 = (idx < 37);
         in_tdata6 = 32'(idx + 1);
         out_tready6 = 1'b1;
         #1;
         if (in_tvalid6 && in_tready6) begin
            if (idx == 36) acc37 = cyc;
            idx++;
         end
         if (out_tvalid6 && out_tready6) begin
            got6.push_back(out_tdata6);
            last_out = cyc;
         end
         cyc++;
      end
      @(negedge clk);
      in_tvalid6 = 1'b0;
      total++;
      if (acc37 < 0 || acc37 != last_out + 1) begin
         bad++;
         $display("FAIL size6_word37: accepted cyc %0d, required %0d",
                  acc37, last_out + 1);
      end
      total++;
      if (got6.size() != 36) begin
         bad++;
         $display("FAIL size6_count: got %0d, required 36", got6.size());
      end
      for (int k = 0; k < 36 && k < got6.size(); k++) begin
         total++;
         if (got6[k] !== ((k % 7 == 0) ? 32'(k + 1) : 32'd0)) begin
            bad++;
            $display("FAIL size6_word%0d: got %0d, required %0d", k, got6[k],
                     (k % 7 == 0) ? k + 1 : 0);
         end
      end
   endtask

   task automatic test_backpressure();
      run4(1, 16, 1, 1'b1, 16);
      total++;
      if (got.size() != 16 || stall_err != 0) begin
         bad++;
         $display("FAIL bp_stall: count %0d stall changes %0d, required 16 0",
                  got.size(), stall_err);
      end
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         total++;
         if (got[k] !== exp4(1, k)) begin
            bad++;
            $display("FAIL bp_word%0d: got %0d, required %0d",
                     k, got[k], exp4(1, k));
         end
      end
   endtask

   task automatic test_input_gaps();
      run4(1, 16, 3, 1'b0, 16);
      total++;
      if (got.size() != 16) begin
         bad++;
         $display("FAIL gaps_count: got %0d, required 16", got.size());
      end
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         total++;
         if (got[k] !== exp4(1, k)) begin
            bad++;
            $display("FAIL gaps_word%0d: got %0d, required %0d",
                     k, got[k], exp4(1, k));
         end
      end
   endtask

   task automatic test_reset_mid_load();
      run4(1, 7, 1, 1'b0, 0);
      @(negedge clk);
      in_tvalid4 = 1'b0;
      rst = 1'b0;
      #1;
      total++;
      if (in_tready4 !== 1'b0 || out_tvalid4 !== 1'b0) begin
         bad++;
         $display("FAIL midload_reset: rdy=%b vld=%b, required 0 0",
                  in_tready4, out_tvalid4);
      end
      @(negedge clk);
      rst = 1'b1;
      run4(101, 16, 1, 1'b0, 16);
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         total++;
         if (got[k] !== exp4(101, k)) begin
            bad++;
            $display("FAIL midload_word%0d: got %0d, required %0d",
                     k, got[k], exp4(101, k));
         end
      end
      total++;
      if (got.size() != 16 || first_out_cyc != last_in_cyc + 1) begin
         bad++;
         $display("FAIL midload_frame: count %0d first %0d, required 16 %0d",
                  got.size(), first_out_cyc, last_in_cyc + 1);
      end
   endtask

   task automatic test_reset_mid_send();
      run4(1, 16, 1, 1'b0, 4);
      @(negedge clk);
      #1;
      total++;
      if (out_tvalid4 !== 1'b1 || out_tdata4 !== 32'd0) begin
         bad++;
         $display("FAIL midsend_word5: vld=%b data=%0d, required 1 0",
                  out_tvalid4, out_tdata4);
      end
      rst = 1'b0;
      #1;
      total++;
      if (out_tvalid4 !== 1'b0 || out_tdata4 !== 32'd0) begin
         bad++;
         $display("FAIL midsend_drop: vld=%b data=%0d, required 0 0",
                  out_tvalid4, out_tdata4);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      total++;
      if (in_tready4 !== 1'b1 || out_tvalid4 !== 1'b0) begin
         bad++;
         $display("FAIL midsend_release: rdy=%b vld=%b, required 1 0",
                  in_tready4, out_tvalid4);
      end
      run4(201, 16, 1, 1'b0, 16);
      total++;
      if (got.size() != 16) begin
         bad++;
         $display("FAIL midsend_count: got %0d, required 16", got.size());
      end
      for (int k = 0; k < 16 && k < got.size(); k++) begin
         total++;
         if (got[k] !== exp4(201, k)) begin
            bad++;
            $display("FAIL midsend_word%0d: got %0d, required %0d",
                     k, got[k], exp4(201, k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_size6();
      test_backpressure();
      test_input_gaps();
      test_reset_mid_load();
      test_reset_mid_send();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/diagonal_matrix.md
Name: diagonal_matrix

Overview:
Streaming matrix-to-diagonal converter. It accepts one SIZE x SIZE matrix as SIZE*SIZE words in row-major order on a valid/ready input stream. It then emits a SIZE x SIZE row-major stream in which diagonal elements keep their input value and every off-diagonal element is zero. It sits between matrix producer and consumer blocks in the matrix-manipulation IP and processes one matrix at a time, with no overlap of load and send.

Parameters:
SIZE, 4, matrix dimension (rows = cols); legal range 2..64.
DATA_WIDTH, 32, bit width of one matrix element.

Ports:
clk  input  1  system clock; all logic on rising edge.
rst  input  1  reset; synchronous, active-low (0 = reset).
in_tdata  input  DATA_WIDTH  input matrix element.
in_tvalid  input  1  in_tdata is valid.
in_tready  output  1  block can accept an input word.
out_tdata  output  DATA_WIDTH  output matrix element.
out_tready  input  1  downstream can accept a word.
out_tvalid  output  1  out_tdata is valid.

Behaviour:
- States: LOAD and SEND. Reset state is LOAD.
- Reset (rst=0 at a rising edge) sets: state=LOAD, row=0, col=0, all diagonal registers=0.
- While rst=0: in_tready=0, out_tvalid=0, out_tdata=0.
- Reset mid-load or mid-send aborts the matrix. No partial output follows reset.
- Counters: row and col, each $clog2(SIZE) bits, shared by LOAD and SEND. col increments per transfer. When col wraps SIZE-1 -> 0, row increments.
- LOAD:
  - in_tready=1, out_tvalid=0, out_tdata=0.
  - Input transfer occurs when in_tvalid & in_tready at a rising edge.
  - On a transfer with row==col, store in_tdata in diag[row]. Off-diagonal words are consumed and discarded.
  - On the transfer with row==SIZE-1 and col==SIZE-1: counters reset to 0 and state -> SEND at the next cycle.
  - in_tvalid=0 stalls the block with no state change. in_tdata is ignored when not transferring.
- SEND:
  - in_tready=0, out_tvalid=1.
  - out_tdata = diag[row] when row==col, else 0. out_tdata is combinational from counters and registers and is stable while out_tready=0.
  - Output transfer occurs when out_tvalid & out_tready at a rising edge, and advances the counters.
  - On the transfer with row==col==SIZE-1: counters reset to 0 and state -> LOAD. in_tready=1 in the following cycle.
- Latency:
  - First output word is valid in the cycle after the last input handshake.
  - With out_tready held at 1, output is SIZE*SIZE consecutive words.
  - Minimum period per matrix is 2*SIZE*SIZE cycles.
- Input words offered during SEND are not accepted (in_tready=0). They must be held by the source and are accepted as element (0,0) of the next matrix.
- Back-pressure: out_tvalid stays high and out_tdata stays stable until accepted (AXI-Stream rule). out_tvalid never drops without a handshake, except under reset.
- No arithmetic is performed. Data passes unmodified at full DATA_WIDTH.

Decomposition:
- Shared package diagonal_matrix_pkg: state enum type (LOAD, SEND) and an index-width helper constant/function based on $clog2.
- One natural sub-module: matrix_index_counter (parameter SIZE; inputs clk, rst, inc; outputs row, col, last). It is instantiated once and its inc is driven by the in-handshake in LOAD and the out-handshake in SEND.

Test Plan:
- SIZE=4, inputs 1..16 back-to-back, out_tready=1 -> outputs 1,0,0,0, 0,6,0,0, 0,0,11,0, 0,0,0,16. First output is one cycle after the 16th input handshake. in_tready=0 for the 16 send cycles.
- SIZE=6, 37 input words offered continuously -> first 36 accepted; output has diagonal = words 1,8,15,22,29,36 and 30 zeros. Word 37 is held and accepted as (0,0) of the next matrix right after the 36th output handshake.
- Output back-pressure: SIZE=4, out_tready toggled 1/0 every cycle -> same 16-word sequence. out_tdata is unchanged across each stalled cycle and no word is duplicated or skipped.
- Input gaps: in_tvalid asserted every third cycle -> same result as back-to-back. Counters advance only on handshakes.
- Reset mid-operation: rst=0 for one edge after 7 inputs, then a fresh matrix 101..116 -> output diagonal 101,106,111,116. No stale data appears.
- Reset mid-send: rst=0 during the 5th output word -> out_tvalid=0 immediately, in_tready=1 after release. A new matrix loads correctly.
